// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: the loader FSM
//   state encoding and the number of bytes that make up one instruction word.
//   No ports; imported by imem_loader and byte_assembler.
package imem_loader_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int BYTES_PER_WORD = WORD_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler
//   Collects a little-endian byte stream into instruction words. Byte k of a
//   word lands in bits [8k+7:8k]. The word register doubles as the memory
//   write-data output, so it holds its value between words.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         discard any partial word (start of a new load)
//   in_valid      a byte is consumed this cycle
//   in_byte       the byte being consumed
//   word          assembled word (complete once word_valid has fired)
//   word_valid    high in the cycle the last byte of a word is consumed
module byte_assembler
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [CW-1:0] count;

   assign word_valid = in_valid && (count == CW'(BYTES - 1));

   // Shifting each new byte in at the top leaves the first byte of the word
   // in the low lane once all BYTES bytes have arrived.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
         word  <= '0;
      end else if (in_valid) begin
         word  <= {in_byte, word[DATA_WIDTH-1:8]};
         count <= word_valid ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program into instruction memory before the processor runs.
//   Bytes arrive over a valid/ready handshake, are packed into words, and
//   each word is written at byte address word_index * 4. The processor is
//   held in reset until the requested number of words has been written.
// Handshake: a byte is consumed in a cycle where byte_valid && byte_ready;
//   byte_ready is high only while receiving, so bytes offered in any other
//   state are left untouched for the source.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_words    load request and its word count (checked on accept)
//   byte_valid/ready    byte stream handshake, byte_data the byte
//   mem_we/addr/wdata   instruction memory write port
//   cpu_rst             processor reset, low only after a completed load
//   busy/done/error     status flags
//   dbg_state           current FSM state for observation
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_SIZE      = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] num_words,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_rst,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [2:0]               dbg_state
);

   localparam int BYTES = DATA_WIDTH / 8;

   state_t                   state, state_next;
   logic [ADDRESS_WIDTH-1:0] word_idx;
   logic [ADDRESS_WIDTH-1:0] count_latched;
   logic                     handshake;
   logic                     word_valid;
   logic                     start_open;
   logic                     count_bad;
   logic                     start_accept;
   logic                     last_word;
   logic                     ready_next, we_next, cpu_rst_next;
   logic                     busy_next, done_next, error_next;

   assign handshake    = byte_valid && byte_ready;
   assign start_open   = start && (state == IDLE || state == DONE || state == ERROR);
   assign count_bad    = (num_words == '0) || (num_words > ADDRESS_WIDTH'(MEM_SIZE));
   assign start_accept = start_open && !count_bad;
   assign last_word    = (word_idx + ADDRESS_WIDTH'(1)) == count_latched;
   assign mem_addr     = word_idx << $clog2(BYTES);
   assign dbg_state    = state;

   byte_assembler #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_accept),
      .in_valid  (handshake),
      .in_byte   (byte_data),
      .word      (mem_wdata),
      .word_valid(word_valid)
   );

   // State and registered outputs. Outputs are decoded from the next state
   // so that they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         cpu_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_next;
         byte_ready <= ready_next;
         mem_we     <= we_next;
         cpu_rst    <= cpu_rst_next;
         busy       <= busy_next;
         done       <= done_next;
         error      <= error_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) state_next = count_bad ? ERROR : RECV;
         end
         RECV:    if (word_valid) state_next = WRITE;
         WRITE:   state_next = last_word ? DONE : RECV;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_next   = (state_next == RECV);
      we_next      = (state_next == WRITE);
      busy_next    = (state_next == RECV) || (state_next == WRITE);
      done_next    = (state_next == DONE);
      error_next   = (state_next == ERROR);
      cpu_rst_next = (state_next != DONE);
   end

   // Word index advances as each write retires; the count is captured only
   // on an accepted start so a start during a load cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx      <= '0;
         count_latched <= '0;
      end else if (start_accept) begin
         word_idx      <= '0;
         count_latched <= num_words;
      end else if (state == WRITE) begin
         word_idx      <= word_idx + ADDRESS_WIDTH'(1);
      end
   end

endmodule
